spi_slv16: RTL and testbench



---
 rtl/spi_pkg.sv | 8 +
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_slv16.sv | 116 +++++++++++
 tb/tb_spi_slv16.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: frame width and controller states.
package spi_pkg;

  localparam int SPI_WIDTH = 16;

  typedef enum logic {IDLE, SHIFT} spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Three-flop synchronizer with rise/fall pulses; edges are reported only after
// the input has been seen at its reset level, so a line already active at reset
// release never produces an edge.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] ff;
  logic       primed;
  logic       armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff     <= {3{RST_VAL}};
      primed <= 1'b0;
      armed  <= 1'b0;
    end else begin
      ff     <= {ff[1:0], din};
      primed <= 1'b1;
      // ff[0] holds a real pin sample only once primed is set
      if (primed && (ff[0] == RST_VAL))
        armed <= 1'b1;
    end
  end

  assign level = ff[1];
  assign rise  = armed & ff[1] & ~ff[2];
  assign fall  = armed & ~ff[1] & ff[2];

endmodule

// File: rtl/spi_slv16.sv
// 16-bit SPI responder: oversamples SS_n/SCLK/MOSI in the clk domain, captures
// the command shifted in and returns a preloaded response on MISO.
module spi_slv16
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic             wrt,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             clr_cmd_rdy,
  output logic [WIDTH-1:0] cmd,
  output logic             cmd_rdy,
  output logic             frm_err
);

  localparam int CW = $clog2(WIDTH + 2);

  spi_slv_state_t state, state_nxt;

  logic             ss_sync, ss_rise, ss_fall;
  logic             sclk_sync, sclk_rise, sclk_fall;
  logic [1:0]       mosi_ff;
  logic [WIDTH-1:0] tx_buf;
  logic [WIDTH-1:0] shft;
  logic [CW-1:0]    bit_cnt;
  logic             unused_sclk;

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (SS_n),
    .level (ss_sync),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (SCLK),
    .level (sclk_sync),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  assign unused_sclk = sclk_sync ^ sclk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_ff <= '0;
    else        mosi_ff <= {mosi_ff[0], MOSI};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = SHIFT;
      SHIFT:   if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf  <= '0;
      shft    <= '0;
      bit_cnt <= '0;
      cmd     <= '0;
      cmd_rdy <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      frm_err <= 1'b0;
      if (wrt)
        tx_buf <= tx_data;
      if (clr_cmd_rdy)
        cmd_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            shft    <= wrt ? tx_data : tx_buf;
            bit_cnt <= '0;
            cmd_rdy <= 1'b0;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            if (bit_cnt == CW'(WIDTH)) begin
              cmd     <= shft;
              cmd_rdy <= 1'b1;
            end else begin
              frm_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            shft <= {shft[WIDTH-2:0], mosi_ff[1]};
            if (bit_cnt != CW'(WIDTH + 1))
              bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign MISO = ss_sync ? 1'bz : shft[WIDTH-1];

endmodule

// File: tb/tb_spi_slv16.sv
// Scoreboard bench for spi_slv16: a bus-level master drives frames, a monitor
// compares every new cmd_rdy against queued expected commands.
module tb_spi_slv16;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        wrt = 1'b0;
  logic [15:0] tx_data = '0;
  logic        clr_cmd_rdy = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;
  wire         MISO;

  pullup (MISO);

  spi_slv16 #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .SS_n        (SS_n),
    .SCLK        (SCLK),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .wrt         (wrt),
    .tx_data     (tx_data),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .frm_err     (frm_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_tx = '0;
  logic [15:0] model_cmd = '0;
  int          exp_err = 0;
  int          seen_err = 0;
  logic        prev_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (rst_n) begin
      if (frm_err) seen_err++;
      if (cmd_rdy && !prev_rdy) begin
        if (exp_q.size() == 0) chk("unexpected_cmd_rdy", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("cmd_on_rdy", {16'd0, cmd}, {16'd0, e});
        end
      end
    end
    prev_rdy = cmd_rdy;
  end

  task automatic load(input logic [15:0] v);
    @(negedge clk);
    wrt = 1'b1;
    tx_data = v;
    @(negedge clk);
    wrt = 1'b0;
    model_tx = v;
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  // Master: SCLK idles high, data changes on the fall, both ends sample on the rise.
  task automatic frame(input logic [15:0] mo, input int nbits, input int rst_at,
                       input bit do_wrt, input logic [15:0] wv);
    logic [15:0] mi;
    logic [15:0] resp;
    bit          aborted;
    mi = '0;
    aborted = 1'b0;
    resp = model_tx;
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
    chk("cmd_rdy_clear_at_start", {31'd0, cmd_rdy}, 32'd0);
    for (int i = 0; i < nbits; i++) begin
      if (do_wrt && i == 8) begin
        @(negedge clk);
        wrt = 1'b1;
        tx_data = wv;
        @(negedge clk);
        wrt = 1'b0;
        model_tx = wv;
      end
      if (rst_at > 0 && i == rst_at) begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("miso_hiz_in_reset", {31'd0, MISO}, 32'd1);
        chk("cmd_in_reset", {16'd0, cmd}, 32'd0);
        chk("cmd_rdy_in_reset", {31'd0, cmd_rdy}, 32'd0);
        rst_n = 1'b1;
        model_tx = '0;
        model_cmd = '0;
        aborted = 1'b1;
      end
      SCLK = 1'b0;
      MOSI = mo[15-i];
      #50;
      SCLK = 1'b1;
      mi[15-i] = MISO;
      #50;
    end
    SS_n = 1'b1;
    if (!aborted) begin
      if (nbits == 16) begin
        exp_q.push_back(mo);
        model_cmd = mo;
        chk("miso_response", {16'd0, mi}, {16'd0, resp});
      end else begin
        exp_err++;
      end
    end
  endtask

  initial begin
    logic [15:0] r;
    repeat (3) @(negedge clk);
    chk("reset_cmd", {16'd0, cmd}, 32'd0);
    chk("reset_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("reset_frm_err", {31'd0, frm_err}, 32'd0);
    chk("reset_miso_hiz", {31'd0, MISO}, 32'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_miso_hiz", {31'd0, MISO}, 32'd1);

    // basic frame
    load(16'h0C00);
    frame(16'hA5C3, 16, 0, 1'b0, '0);
    settle();
    chk("basic_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    chk("basic_cmd", {16'd0, cmd}, {16'd0, model_cmd});
    @(negedge clk) clr_cmd_rdy = 1'b1;
    @(negedge clk) clr_cmd_rdy = 1'b0;
    chk("clr_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);

    // short frame
    frame(16'h5A5A, 8, 0, 1'b0, '0);
    settle();
    chk("short_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("short_cmd_kept", {16'd0, cmd}, {16'd0, model_cmd});
    chk("short_frm_err_count", seen_err, exp_err);

    // mid-frame wrt
    load(16'h1234);
    frame(16'($urandom), 16, 0, 1'b1, 16'hBEEF);
    settle();
    frame(16'($urandom), 16, 0, 1'b0, '0);
    settle();

    // back-to-back frames without acknowledge
    load(16'($urandom));
    frame(16'h0001, 16, 0, 1'b0, '0);
    settle();
    chk("b2b_first_rdy", {31'd0, cmd_rdy}, 32'd1);
    frame(16'hFFFE, 16, 0, 1'b0, '0);
    settle();
    chk("b2b_second_rdy", {31'd0, cmd_rdy}, 32'd1);
    chk("b2b_cmd", {16'd0, cmd}, 32'h0000FFFE);

    // reset in the middle of a frame
    load(16'h7E81);
    frame(16'h3C3C, 16, 6, 1'b0, '0);
    settle();
    chk("rst_mid_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("rst_mid_cmd", {16'd0, cmd}, {16'd0, model_cmd});
    chk("rst_mid_frm_err", seen_err, exp_err);
    load(16'h8421);
    frame(16'hC0DE, 16, 0, 1'b0, '0);
    settle();
    chk("after_rst_cmd", {16'd0, cmd}, 32'h0000C0DE);

    // set/clear collision: clr held until cmd_rdy is seen, then dropped
    clr_cmd_rdy = 1'b1;
    frame(16'($urandom), 16, 0, 1'b0, '0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cmd_rdy) break;
    end
    clr_cmd_rdy = 1'b0;
    chk("collision_set_wins", {31'd0, cmd_rdy}, 32'd1);
    repeat (2) @(negedge clk);
    chk("collision_held", {31'd0, cmd_rdy}, 32'd1);
    settle();

    // randomized frames, occasionally short
    for (int n = 0; n < 8; n++) begin
      r = 16'($urandom);
      load(r);
      if ($urandom_range(0, 3) == 0) frame(16'($urandom), $urandom_range(1, 15), 0, 1'b0, '0);
      else frame(16'($urandom), 16, 0, 1'b0, '0);
      settle();
      chk("rand_cmd", {16'd0, cmd}, {16'd0, model_cmd});
      @(negedge clk) clr_cmd_rdy = 1'b1;
      @(negedge clk) clr_cmd_rdy = 1'b0;
    end

    chk("final_frm_err_count", seen_err, exp_err);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
